// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state codes,
// counter sizing helper and the divide-by-zero quotient constant.
package div_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  localparam int DIV_MAX_W = 64;
  localparam logic [DIV_MAX_W-1:0] DIV_ZERO_Q = '1;

  function automatic int clog2(input int value);
    int bits;
    bits = 0;
    for (int v = value - 1; v > 0; v = v >> 1) bits++;
    return bits;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// trial-subtract the divisor and keep the difference when it does not borrow.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] trial;

  // The trial value is one bit wider than the divisor, so the compare never overflows.
  assign trial    = {rem, bit_in};
  assign q_bit    = (trial >= {1'b0, divisor});
  assign rem_next = q_bit ? (trial[WIDTH-1:0] - divisor) : trial[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, start/done handshake.
// Define DIV_SIGNED_EN for two's-complement operands (magnitude divide plus sign fix-up).
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_work, dvd_work, dsr_work;
  logic [WIDTH-1:0] rem_step;
  logic             q_bit;
  logic [WIDTH-1:0] dvd_in, dsr_in;
  logic [WIDTH-1:0] q_mag, r_mag, q_fix, r_fix;
  logic             accept, last_step, zero_div;

  assign zero_div  = (divisor == '0);
  assign accept    = (state == IDLE) && start;
  assign last_step = (state == CALC) && (cnt == '0);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_work),
    .bit_in   (dvd_work[WIDTH-1]),
    .divisor  (dsr_work),
    .rem_next (rem_step),
    .q_bit    (q_bit)
  );

  // Quotient bits shift into the vacated low end of the dividend register.
  assign q_mag = {dvd_work[WIDTH-2:0], q_bit};
  assign r_mag = rem_step;

`ifdef DIV_SIGNED_EN
  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag,
                                                  input logic             neg);
    return neg ? (~mag + WIDTH'(1)) : mag;
  endfunction

  logic signed [WIDTH-1:0] dividend_s, divisor_s;
  logic                    neg_q, neg_r;

  assign dividend_s = dividend;
  assign divisor_s  = divisor;
  assign dvd_in     = apply_sign(dividend, dividend_s < 0);
  assign dsr_in     = apply_sign(divisor, divisor_s < 0);
  // MIN / -1 falls out naturally: magnitude 2^(W-1) negated wraps back to MIN.
  assign q_fix      = apply_sign(q_mag, neg_q);
  assign r_fix      = apply_sign(r_mag, neg_r);

  always_ff @(posedge clk) begin
    if (accept) begin
      neg_q <= (dividend_s < 0) ^ (divisor_s < 0);
      neg_r <= (dividend_s < 0);
    end
  end
`else
  assign dvd_in = dividend;
  assign dsr_in = divisor;
  assign q_fix  = q_mag;
  assign r_fix  = r_mag;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = zero_div ? FIN : CALC;
      CALC:    if (cnt == '0) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CALC) || (state == FIN);
    done = (state == FIN);
  end

  // Working registers carry no reset; they are always reloaded on acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      rem_work <= '0;
      dvd_work <= dvd_in;
      dsr_work <= dsr_in;
    end else if (state == CALC) begin
      rem_work <= rem_step;
      dvd_work <= q_mag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      cnt         <= CNT_W'(WIDTH - 1);
      div_by_zero <= zero_div;
      if (zero_div) begin
        quotient  <= DIV_ZERO_Q[WIDTH-1:0];
        remainder <= dividend;
      end
    end else if (state == CALC) begin
      cnt <= cnt - CNT_W'(1);
      if (last_step) begin
        quotient  <= q_fix;
        remainder <= r_fix;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed corner cases plus random operand pairs
// checked against an arithmetic reference model.
module tb_seq_divider;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           due;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  exp_t         sb[$];
  int           compared = 0;
  int           mismatched = 0;
  int           cyc = 0;
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.a = a;
    e.b = b;
    e.due = 0;
    if (b == '0) begin
      e.q  = '1;
      e.r  = a;
      e.dz = 1'b1;
    end else begin
`ifdef DIV_SIGNED_EN
      longint sa, sbv;
      sa   = longint'($signed(a));
      sbv  = longint'($signed(b));
      e.q  = W'(sa / sbv);
      e.r  = W'(sa % sbv);
`else
      e.q  = a / b;
      e.r  = a % b;
`endif
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", div_by_zero, e.dz);
        chk("done_cycle", cyc, e.due);
`ifndef DIV_SIGNED_EN
        if (e.b != '0) begin
          chk("identity", {32'd0, quotient} * {32'd0, e.b} + {32'd0, remainder}, {32'd0, e.a});
          chk("rem_lt_divisor", remainder < e.b, 64'd1);
        end
`endif
        last_q = e.q;
        last_r = e.r;
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    @(posedge clk); #1;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    e = model(a, b);
    e.due = cyc + 1 + ((b == '0) ? 0 : W);
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      chk("done_timeout", 64'd0, 64'd1);
      sb.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a, b;
    #3;
    chk("reset_busy", busy, 64'd0);
    chk("reset_done", done, 64'd0);
    chk("reset_quotient", quotient, 64'd0);
    chk("reset_remainder", remainder, 64'd0);
    chk("reset_dz", div_by_zero, 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    issue(32'd100, 32'd7);
    wait_done(W + 5);

    issue(32'h1234_5678, 32'd0);
    wait_done(5);

    // Busy guard: a second start mid-operation must be ignored.
    issue(32'hFFFF_FFFF, 32'h10);
    repeat (7) @(posedge clk);
    #1;
    chk("busy_mid_calc", busy, 64'd1);
    chk("quotient_held", quotient, last_q);
    chk("remainder_held", remainder, last_r);
    dividend = 32'd5;
    divisor  = 32'd1;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(W + 5);
    issue(32'd5, 32'd1);
    wait_done(W + 5);
    @(negedge clk);
    chk("idle_after_done", busy, 64'd0);

    // Reset mid-operation aborts without a done pulse.
    issue(32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    sb.delete();
    #1;
    chk("abort_busy", busy, 64'd0);
    chk("abort_done", done, 64'd0);
    chk("abort_quotient", quotient, 64'd0);
    chk("abort_remainder", remainder, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (W + 5) @(posedge clk);
    issue(32'd9, 32'd3);
    wait_done(W + 5);

`ifdef DIV_SIGNED_EN
    issue(-32'sd7, 32'sd2);
    wait_done(W + 5);
    issue(32'sd7, -32'sd2);
    wait_done(W + 5);
    issue(32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(W + 5);
    issue(32'h8000_0000, 32'd0);
    wait_done(5);
`endif

    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 31);
      b = $urandom;
      b = b >> $urandom_range(0, 31);
      if (b == '0) b = 32'd1;
      issue(a, b);
      wait_done(W + 5);
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
